// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and sizing for the unified memory-port arbiter and its tag owner table.
// Also provides a default `XLEN when the surrounding build has not defined one.
`ifndef XLEN
`define XLEN 32
`endif

package mem_bus_arbiter_pkg;

    localparam int NUM_TAGS     = 15;
    localparam int TAG_W        = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DC = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
        logic     squashed;
    } MEM_TAG_ENTRY;

    // Counts consecutive denied fetch cycles without wrapping past the limit.
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        return (cnt == STARVE_W'(STARVE_LIMIT)) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt, input logic en);
        return (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, data-side and proc2mem/mem2proc signals around the arbiter.
// Statistics outputs appear only when MEM_ARB_STATS_EN is defined.
interface mem_bus_arbiter_if import mem_bus_arbiter_pkg::*; ();

    // Handshake: a requester raises *_req_valid and holds its fields until the
    // cycle in which *_req_accepted is 1; responses are single-cycle pulses.
    logic                if_req_valid;
    logic [`XLEN-1:0]    if_req_addr;
    logic                if_flush;
    logic                if_req_accepted;
    logic                if_resp_valid;
    logic [TAG_W-1:0]    if_resp_tag;
    logic [63:0]         if_resp_data;

    logic                dc_req_valid;
    BUS_COMMAND          dc_req_cmd;
    logic [`XLEN-1:0]    dc_req_addr;
    logic [63:0]         dc_req_data;
    logic                dc_req_accepted;
    logic [TAG_W-1:0]    dc_req_tag;
    logic                dc_resp_valid;
    logic [TAG_W-1:0]    dc_resp_tag;
    logic [63:0]         dc_resp_data;

    BUS_COMMAND          proc2mem_command;
    logic [`XLEN-1:0]    proc2mem_addr;
    logic [63:0]         proc2mem_data;
    logic [TAG_W-1:0]    mem2proc_response;
    logic [63:0]         mem2proc_data;
    logic [TAG_W-1:0]    mem2proc_tag;

`ifdef MEM_ARB_STATS_EN
    logic [31:0]         stat_if_grants;
    logic [31:0]         stat_dc_grants;
    logic [31:0]         stat_rejects;
    logic [31:0]         stat_squashed_drops;
`endif

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output if_req_accepted, if_resp_valid, if_resp_tag, if_resp_data,
        output dc_req_accepted, dc_req_tag, dc_resp_valid, dc_resp_tag, dc_resp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data
`ifdef MEM_ARB_STATS_EN
        , output stat_if_grants, stat_dc_grants, stat_rejects, stat_squashed_drops
`endif
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  if_req_accepted, if_resp_valid, if_resp_tag, if_resp_data,
        input  dc_req_accepted, dc_req_tag, dc_resp_valid, dc_resp_tag, dc_resp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data
`ifdef MEM_ARB_STATS_EN
        , input stat_if_grants, stat_dc_grants, stat_rejects, stat_squashed_drops
`endif
    );

endinterface

// File: rtl/mem_tag_table.sv
// Owner table indexed by memory tag: records which side owns each outstanding tag
// and whether a fetch tag was squashed by a redirect. Tag 0 never holds an entry.
module mem_tag_table import mem_bus_arbiter_pkg::*; (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    input  MEM_OWNER         alloc_owner_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    input  logic             clear_en_i,
    input  logic             flush_i,
    output MEM_TAG_ENTRY     lookup_entry_o
);

    localparam int DEPTH = 1 << TAG_W;

    MEM_TAG_ENTRY entries_q [DEPTH];
    MEM_TAG_ENTRY entries_d [DEPTH];

    assign lookup_entry_o = entries_q[lookup_tag_i];

    // Update order matters: squash, then clear on response, then allocation,
    // so a same-cycle allocation of a returning tag survives.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (i == 0 || i > NUM_TAGS) begin
                entries_d[i] = '0;
            end else begin
                if (flush_i && entries_q[i].valid && entries_q[i].owner == OWNER_IF) begin
                    entries_d[i].squashed = 1'b1;
                end
                if (clear_en_i && lookup_tag_i == TAG_W'(i)) begin
                    entries_d[i] = '0;
                end
                if (alloc_en_i && alloc_tag_i == TAG_W'(i)) begin
                    entries_d[i].valid    = 1'b1;
                    entries_d[i].owner    = alloc_owner_i;
                    entries_d[i].squashed = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                entries_q[i] <= '0;
            end else begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between fetch and the data side, tracks tag
// ownership and routes responses back. Optional counters: define MEM_ARB_STATS_EN.
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    logic         fetch_req;
    logic         fetch_sel;
    logic         dc_sel;
    logic         mem_accept;
    logic         if_acc;
    logic         dc_acc;
    logic         alloc_en;
    MEM_OWNER     alloc_owner;
    logic         resp_present;
    logic         resp_hit;
    MEM_TAG_ENTRY resp_entry;

    // Data side wins by default; fetch wins when starved or when data is idle.
    // A fetch raised in a redirect cycle is stale and never reaches memory.
    always_comb begin
        fetch_req  = reset && bus.if_req_valid && !bus.if_flush;
        fetch_sel  = fetch_req && ((starve_q == STARVE_W'(STARVE_LIMIT)) || !bus.dc_req_valid);
        dc_sel     = reset && bus.dc_req_valid && !fetch_sel;
        mem_accept = (bus.mem2proc_response != '0);
        if_acc     = fetch_sel && mem_accept;
        dc_acc     = dc_sel && mem_accept;
    end

    always_comb begin
        alloc_en    = if_acc || (dc_acc && bus.dc_req_cmd == BUS_LOAD);
        alloc_owner = if_acc ? OWNER_IF : OWNER_DC;
    end

    assign bus.proc2mem_command = fetch_sel ? BUS_LOAD :
                                  (dc_sel ? bus.dc_req_cmd : BUS_NONE);
    assign bus.proc2mem_addr    = fetch_sel ? bus.if_req_addr :
                                  (dc_sel ? bus.dc_req_addr : '0);
    assign bus.proc2mem_data    = (dc_sel && bus.dc_req_cmd == BUS_STORE) ? bus.dc_req_data : '0;

    assign bus.if_req_accepted  = if_acc;
    assign bus.dc_req_accepted  = dc_acc;
    assign bus.dc_req_tag       = dc_acc ? bus.mem2proc_response : '0;

    mem_tag_table u_tag_table (
        .clock          (clock),
        .reset          (reset),
        .alloc_en_i     (alloc_en),
        .alloc_tag_i    (bus.mem2proc_response),
        .alloc_owner_i  (alloc_owner),
        .lookup_tag_i   (bus.mem2proc_tag),
        .clear_en_i     (resp_present),
        .flush_i        (bus.if_flush),
        .lookup_entry_o (resp_entry)
    );

    assign resp_present = reset && (bus.mem2proc_tag != '0);
    assign resp_hit     = resp_present && resp_entry.valid;

    // A fetch response in the redirect cycle itself belongs to the old path.
    assign bus.dc_resp_valid = resp_hit && (resp_entry.owner == OWNER_DC);
    assign bus.if_resp_valid = resp_hit && (resp_entry.owner == OWNER_IF) &&
                               !resp_entry.squashed && !bus.if_flush;
    assign bus.dc_resp_tag   = bus.mem2proc_tag;
    assign bus.dc_resp_data  = bus.mem2proc_data;
    assign bus.if_resp_tag   = bus.mem2proc_tag;
    assign bus.if_resp_data  = bus.mem2proc_data;

    always_comb begin
        if (!bus.if_req_valid || bus.if_flush || if_acc) begin
            starve_d = '0;
        end else begin
            starve_d = starve_inc(starve_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_q;
    logic [31:0] stat_dc_q;
    logic [31:0] stat_rej_q;
    logic [31:0] stat_drop_q;
    logic        squash_drop;
    logic        reject;

    assign reject      = (fetch_sel || dc_sel) && !mem_accept;
    assign squash_drop = resp_hit && (resp_entry.owner == OWNER_IF) &&
                         (resp_entry.squashed || bus.if_flush);

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_if_q   <= '0;
            stat_dc_q   <= '0;
            stat_rej_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_if_q   <= sat_inc32(stat_if_q, if_acc);
            stat_dc_q   <= sat_inc32(stat_dc_q, dc_acc);
            stat_rej_q  <= sat_inc32(stat_rej_q, reject);
            stat_drop_q <= sat_inc32(stat_drop_q, squash_drop);
        end
    end

    assign bus.stat_if_grants      = stat_if_q;
    assign bus.stat_dc_grants      = stat_dc_q;
    assign bus.stat_rejects        = stat_rej_q;
    assign bus.stat_squashed_drops = stat_drop_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// tag-ownership model kept in plain arrays and integers.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: owner_m 0 = free, 1 = fetch, 2 = data side.
  int owner_m [16];
  bit sq_m    [16];
  int starve_m;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.if_req_valid      = 1'b0;
    bus.if_req_addr       = '0;
    bus.if_flush          = 1'b0;
    bus.dc_req_valid      = 1'b0;
    bus.dc_req_cmd        = BUS_LOAD;
    bus.dc_req_addr       = '0;
    bus.dc_req_data       = '0;
    bus.mem2proc_response = '0;
    bus.mem2proc_data     = '0;
    bus.mem2proc_tag      = '0;
  endtask

  // Checks all outputs for the inputs currently applied, then advances one clock
  // and applies the cycle's effects to the model.
  task automatic cyc();
    logic e_fetch, e_dc, e_if_acc, e_dc_acc, e_ifr, e_dcr;
    logic if_v, flush;
    BUS_COMMAND e_cmd, cmd;
    logic [63:0] e_addr, e_data;
    logic [TAG_W-1:0] resp, mtag;
    int own;
    #1;
    resp  = bus.mem2proc_response;
    mtag  = bus.mem2proc_tag;
    if_v  = bus.if_req_valid;
    flush = bus.if_flush;
    cmd   = bus.dc_req_cmd;
    e_fetch  = reset && if_v && !flush && (starve_m == STARVE_LIMIT || !bus.dc_req_valid);
    e_dc     = reset && bus.dc_req_valid && !e_fetch;
    e_if_acc = e_fetch && (resp != 0);
    e_dc_acc = e_dc && (resp != 0);
    e_cmd    = e_fetch ? BUS_LOAD : (e_dc ? cmd : BUS_NONE);
    e_addr   = e_fetch ? 64'(bus.if_req_addr) : (e_dc ? 64'(bus.dc_req_addr) : 64'd0);
    e_data   = (e_dc && cmd == BUS_STORE) ? bus.dc_req_data : 64'd0;
    own      = (reset && mtag != 0) ? owner_m[mtag] : 0;
    e_dcr    = (own == 2);
    e_ifr    = (own == 1) && !sq_m[mtag] && !flush;

    chk("proc2mem_command", 64'(bus.proc2mem_command), 64'(e_cmd));
    chk("proc2mem_addr", 64'(bus.proc2mem_addr), e_addr);
    chk("proc2mem_data", bus.proc2mem_data, e_data);
    chk("if_req_accepted", 64'(bus.if_req_accepted), 64'(e_if_acc));
    chk("dc_req_accepted", 64'(bus.dc_req_accepted), 64'(e_dc_acc));
    chk("if_resp_valid", 64'(bus.if_resp_valid), 64'(e_ifr));
    chk("dc_resp_valid", 64'(bus.dc_resp_valid), 64'(e_dcr));
    if (e_dc_acc) chk("dc_req_tag", 64'(bus.dc_req_tag), 64'(resp));
    if (e_ifr) begin
      chk("if_resp_tag", 64'(bus.if_resp_tag), 64'(mtag));
      chk("if_resp_data", bus.if_resp_data, bus.mem2proc_data);
    end
    if (e_dcr) begin
      chk("dc_resp_tag", 64'(bus.dc_resp_tag), 64'(mtag));
      chk("dc_resp_data", bus.dc_resp_data, bus.mem2proc_data);
    end

    @(posedge clock);
    if (!reset) begin
      for (int t = 0; t < 16; t++) begin
        owner_m[t] = 0;
        sq_m[t]    = 1'b0;
      end
      starve_m = 0;
    end else begin
      if (flush) begin
        for (int t = 0; t < 16; t++) if (owner_m[t] == 1) sq_m[t] = 1'b1;
      end
      if (mtag != 0) begin
        owner_m[mtag] = 0;
        sq_m[mtag]    = 1'b0;
      end
      if (e_if_acc) begin
        owner_m[resp] = 1;
        sq_m[resp]    = 1'b0;
      end else if (e_dc_acc && cmd == BUS_LOAD) begin
        owner_m[resp] = 2;
        sq_m[resp]    = 1'b0;
      end
      if (!if_v || flush || e_if_acc) starve_m = 0;
      else if (starve_m < STARVE_LIMIT) starve_m++;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    for (int t = 1; t <= NUM_TAGS; t++) begin
      set_idle();
      bus.mem2proc_tag  = TAG_W'(t);
      bus.mem2proc_data = {$urandom, $urandom};
      cyc();
    end
    set_idle();
  endtask

  initial begin
    logic [63:0] sd;
    for (int t = 0; t < 16; t++) begin
      owner_m[t] = 0;
      sq_m[t]    = 1'b0;
    end
    starve_m = 0;
    reset = 1'b0;
    set_idle();
    bus.if_req_valid      = 1'b1;
    bus.dc_req_valid      = 1'b1;
    bus.mem2proc_response = 4'd3;
    @(negedge clock);

    // Reset holds the bus idle even with both sides requesting.
    #1;
    chk("rst_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("rst_if_acc", 64'(bus.if_req_accepted), 64'd0);
    chk("rst_dc_acc", 64'(bus.dc_req_accepted), 64'd0);
    cyc();
    cyc();

    // Fetch alone on tag 3, data returns two cycles later.
    reset = 1'b1;
    set_idle();
    cyc();
    bus.if_req_valid      = 1'b1;
    bus.if_req_addr       = `XLEN'('h100);
    bus.mem2proc_response = 4'd3;
    #1;
    chk("fetch_acc", 64'(bus.if_req_accepted), 64'd1);
    chk("fetch_cmd", 64'(bus.proc2mem_command), 64'(BUS_LOAD));
    chk("fetch_addr", 64'(bus.proc2mem_addr), 64'h100);
    cyc();
    set_idle();
    cyc();
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = 64'hDEADBEEF_CAFEF00D;
    #1;
    chk("fetch_resp_valid", 64'(bus.if_resp_valid), 64'd1);
    chk("fetch_resp_tag", 64'(bus.if_resp_tag), 64'd3);
    chk("fetch_resp_data", bus.if_resp_data, 64'hDEADBEEF_CAFEF00D);
    cyc();

    // Both sides always requesting: four data grants then one fetch grant.
    set_idle();
    cyc();
    for (int i = 0; i < 10; i++) begin
      bus.if_req_valid      = 1'b1;
      bus.if_req_addr       = `XLEN'(32'h200 + 32'(i) * 8);
      bus.dc_req_valid      = 1'b1;
      bus.dc_req_cmd        = BUS_LOAD;
      bus.dc_req_addr       = `XLEN'(32'h1000 + 32'(i) * 8);
      bus.mem2proc_response = TAG_W'(i + 1);
      #1;
      chk("starve_if_acc", 64'(bus.if_req_accepted), 64'((i % 5) == 4));
      chk("starve_dc_acc", 64'(bus.dc_req_accepted), 64'((i % 5) != 4));
      cyc();
    end
    drain();

    // Fetch on tag 5, redirect, then tag 5 returns and is dropped.
    bus.if_req_valid      = 1'b1;
    bus.if_req_addr       = `XLEN'('h300);
    bus.mem2proc_response = 4'd5;
    cyc();
    set_idle();
    bus.if_flush = 1'b1;
    cyc();
    set_idle();
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = {$urandom, $urandom};
    #1;
    chk("squashed_drop", 64'(bus.if_resp_valid), 64'd0);
    cyc();
    set_idle();
    bus.if_req_valid      = 1'b1;
    bus.if_req_addr       = `XLEN'('h308);
    bus.mem2proc_response = 4'd5;
    cyc();
    set_idle();
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = {$urandom, $urandom};
    #1;
    chk("realloc_resp_valid", 64'(bus.if_resp_valid), 64'd1);
    chk("realloc_resp_tag", 64'(bus.if_resp_tag), 64'd5);
    cyc();

    // Fetch response arriving in the redirect cycle itself.
    set_idle();
    bus.if_req_valid      = 1'b1;
    bus.if_req_addr       = `XLEN'('h310);
    bus.mem2proc_response = 4'd6;
    cyc();
    set_idle();
    bus.if_flush     = 1'b1;
    bus.mem2proc_tag = 4'd6;
    #1;
    chk("flush_cycle_drop", 64'(bus.if_resp_valid), 64'd0);
    cyc();
    drain();

    // Stores never allocate, so their tag coming back is ignored.
    sd = {$urandom, $urandom};
    bus.dc_req_valid      = 1'b1;
    bus.dc_req_cmd        = BUS_STORE;
    bus.dc_req_addr       = `XLEN'('h2000);
    bus.dc_req_data       = sd;
    bus.mem2proc_response = 4'd7;
    #1;
    chk("store_acc", 64'(bus.dc_req_accepted), 64'd1);
    chk("store_cmd", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    chk("store_data", bus.proc2mem_data, sd);
    cyc();
    set_idle();
    cyc();
    bus.mem2proc_tag = 4'd7;
    #1;
    chk("store_no_resp", 64'(bus.dc_resp_valid), 64'd0);
    cyc();

    // Load on tag 2, then a one-cycle reset wipes it.
    set_idle();
    bus.dc_req_valid      = 1'b1;
    bus.dc_req_cmd        = BUS_LOAD;
    bus.dc_req_addr       = `XLEN'('h3000);
    bus.mem2proc_response = 4'd2;
    #1;
    chk("load_acc", 64'(bus.dc_req_accepted), 64'd1);
    cyc();
    set_idle();
    reset = 1'b0;
    bus.dc_req_valid      = 1'b1;
    bus.mem2proc_response = 4'd4;
    #1;
    chk("rst_mid_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("rst_mid_dc_acc", 64'(bus.dc_req_accepted), 64'd0);
    cyc();
    reset = 1'b1;
    set_idle();
    bus.mem2proc_tag = 4'd2;
    #1;
    chk("rst_drop", 64'(bus.dc_resp_valid), 64'd0);
    cyc();

    // Memory rejects three times, the held load is taken on the fourth.
    set_idle();
    bus.dc_req_valid = 1'b1;
    bus.dc_req_cmd   = BUS_LOAD;
    bus.dc_req_addr  = `XLEN'('h4000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reject_dc_acc", 64'(bus.dc_req_accepted), 64'd0);
      cyc();
    end
    bus.mem2proc_response = 4'd9;
    #1;
    chk("reject_then_acc", 64'(bus.dc_req_accepted), 64'd1);
    chk("reject_then_tag", 64'(bus.dc_req_tag), 64'd9);
    cyc();
    set_idle();
    sd = {$urandom, $urandom};
    bus.mem2proc_tag  = 4'd9;
    bus.mem2proc_data = sd;
    #1;
    chk("load_resp_valid", 64'(bus.dc_resp_valid), 64'd1);
    chk("load_resp_data", bus.dc_resp_data, sd);
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset                 = ($urandom_range(0, 49) != 0);
      bus.if_req_valid      = 1'($urandom_range(0, 1));
      bus.if_req_addr       = `XLEN'($urandom & 32'hFFFF_FFF8);
      bus.if_flush          = ($urandom_range(0, 9) == 0);
      bus.dc_req_valid      = 1'($urandom_range(0, 1));
      bus.dc_req_cmd        = ($urandom_range(0, 1) != 0) ? BUS_STORE : BUS_LOAD;
      bus.dc_req_addr       = `XLEN'($urandom);
      bus.dc_req_data       = {$urandom, $urandom};
      bus.mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : TAG_W'($urandom_range(1, NUM_TAGS));
      bus.mem2proc_tag      = TAG_W'($urandom_range(0, NUM_TAGS));
      bus.mem2proc_data     = {$urandom, $urandom};
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
